// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execute stage: decodes alu_op/funct into a 4-bit control code,
// computes the result and flags combinationally, and registers everything once per clock.
module alu_exec_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  alu_op,
    input  logic [5:0]  funct,
    input  logic        branch,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        take_branch
);

    localparam logic [3:0] CTRL_AND  = 4'b0000;
    localparam logic [3:0] CTRL_OR   = 4'b0001;
    localparam logic [3:0] CTRL_ADD  = 4'b0010;
    localparam logic [3:0] CTRL_XOR  = 4'b0011;
    localparam logic [3:0] CTRL_SUB  = 4'b0110;
    localparam logic [3:0] CTRL_SLT  = 4'b0111;
    localparam logic [3:0] CTRL_SLTU = 4'b1000;
    localparam logic [3:0] CTRL_NOR  = 4'b1100;

    logic [3:0]  alu_ctrl_d, alu_ctrl_q;
    logic [31:0] result_d, result_q;
    logic        zero_d, zero_q;
    logic        overflow_d, overflow_q;
    logic        take_branch_d, take_branch_q;

    logic [31:0] sum;
    logic [31:0] diff;
    logic        slt_bit;
    logic        sltu_bit;

    always_comb begin
        alu_ctrl_d = CTRL_ADD;
        case (alu_op)
            2'b00: alu_ctrl_d = CTRL_ADD;
            2'b01: alu_ctrl_d = CTRL_SUB;
            2'b11: alu_ctrl_d = CTRL_ADD;
            default: begin
                case (funct)
                    6'b100000, 6'b100001: alu_ctrl_d = CTRL_ADD;
                    6'b100010, 6'b100011: alu_ctrl_d = CTRL_SUB;
                    6'b100100:            alu_ctrl_d = CTRL_AND;
                    6'b100101:            alu_ctrl_d = CTRL_OR;
                    6'b100110:            alu_ctrl_d = CTRL_XOR;
                    6'b100111:            alu_ctrl_d = CTRL_NOR;
                    6'b101010:            alu_ctrl_d = CTRL_SLT;
                    6'b101011:            alu_ctrl_d = CTRL_SLTU;
                    default:              alu_ctrl_d = CTRL_ADD;
                endcase
            end
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;
    // With differing signs the negative operand is smaller; with equal signs the
    // difference cannot overflow, so its sign bit is the answer.
    assign slt_bit  = (a[31] != b[31]) ? a[31] : diff[31];
    assign sltu_bit = (a < b);

    always_comb begin
        result_d   = 32'd0;
        overflow_d = 1'b0;
        case (alu_ctrl_d)
            CTRL_AND:  result_d = a & b;
            CTRL_OR:   result_d = a | b;
            CTRL_ADD: begin
                result_d   = sum;
                overflow_d = (a[31] == b[31]) && (sum[31] != a[31]);
            end
            CTRL_SUB: begin
                result_d   = diff;
                overflow_d = (a[31] != b[31]) && (diff[31] != a[31]);
            end
            CTRL_XOR:  result_d = a ^ b;
            CTRL_NOR:  result_d = ~(a | b);
            CTRL_SLT:  result_d = {31'd0, slt_bit};
            CTRL_SLTU: result_d = {31'd0, sltu_bit};
            default:   result_d = 32'd0;
        endcase
    end

    assign zero_d        = (result_d == 32'd0);
    assign take_branch_d = branch & zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_ctrl_q    <= 4'd0;
            result_q      <= 32'd0;
            zero_q        <= 1'b0;
            overflow_q    <= 1'b0;
            take_branch_q <= 1'b0;
        end else begin
            alu_ctrl_q    <= alu_ctrl_d;
            result_q      <= result_d;
            zero_q        <= zero_d;
            overflow_q    <= overflow_d;
            take_branch_q <= take_branch_d;
        end
    end

    assign alu_ctrl    = alu_ctrl_q;
    assign result      = result_q;
    assign zero        = zero_q;
    assign overflow    = overflow_q;
    assign take_branch = take_branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// back-to-back traffic compared against an arithmetic reference model.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  alu_op;
    logic [5:0]  funct;
    logic        branch;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        take_branch;

    int total;
    int bad;

    alu_exec_unit dut (
        .clk         (clk),
        .rst         (rst),
        .alu_op      (alu_op),
        .funct       (funct),
        .branch      (branch),
        .a           (a),
        .b           (b),
        .alu_ctrl    (alu_ctrl),
        .result      (result),
        .zero        (zero),
        .overflow    (overflow),
        .take_branch (take_branch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: decode table plus plain integer arithmetic.
    function automatic void model(input logic [1:0] op, input logic [5:0] f, input logic br,
                                  input logic [31:0] x, input logic [31:0] y,
                                  output logic [3:0] e_ctrl, output logic [31:0] e_res,
                                  output logic e_zero, output logic e_ov, output logic e_tb);
        longint sx, sy, wide;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (op == 2'b01) e_ctrl = 4'b0110;
        else if (op != 2'b10) e_ctrl = 4'b0010;
        else if (f == 6'd32 || f == 6'd33) e_ctrl = 4'b0010;
        else if (f == 6'd34 || f == 6'd35) e_ctrl = 4'b0110;
        else if (f == 6'd36) e_ctrl = 4'b0000;
        else if (f == 6'd37) e_ctrl = 4'b0001;
        else if (f == 6'd38) e_ctrl = 4'b0011;
        else if (f == 6'd39) e_ctrl = 4'b1100;
        else if (f == 6'd42) e_ctrl = 4'b0111;
        else if (f == 6'd43) e_ctrl = 4'b1000;
        else e_ctrl = 4'b0010;
        e_ov = 1'b0;
        e_res = 32'd0;
        if (e_ctrl == 4'b0010) begin
            wide  = sx + sy;
            e_res = wide[31:0];
            e_ov  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (e_ctrl == 4'b0110) begin
            wide  = sx - sy;
            e_res = wide[31:0];
            e_ov  = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
        end else if (e_ctrl == 4'b0000) e_res = x & y;
        else if (e_ctrl == 4'b0001) e_res = x | y;
        else if (e_ctrl == 4'b0011) e_res = x ^ y;
        else if (e_ctrl == 4'b1100) e_res = ~(x | y);
        else if (e_ctrl == 4'b0111) e_res = (sx < sy) ? 32'd1 : 32'd0;
        else if (e_ctrl == 4'b1000) e_res = (x < y) ? 32'd1 : 32'd0;
        e_zero = (e_res == 32'd0);
        e_tb   = br & e_zero;
    endfunction

    task automatic drive_step(input logic [1:0] op, input logic [5:0] f, input logic br,
                              input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        alu_op = op; funct = f; branch = br; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive_step(2'b01, 6'd0, 1'b1, 32'd5, 32'd5);
            total++;
            if ({alu_ctrl, result, zero, overflow, take_branch} !== 39'd0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got ctrl=%b res=%h z=%b ov=%b tb=%b want all 0",
                         i, alu_ctrl, result, zero, overflow, take_branch);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (alu_ctrl !== 4'b0110 || result !== 32'd0 || zero !== 1'b1 || take_branch !== 1'b1
            || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_release got ctrl=%b res=%h z=%b ov=%b tb=%b want ctrl=0110 res=0 z=1 ov=0 tb=1",
                     alu_ctrl, result, zero, overflow, take_branch);
        end
        $display("reset: ctrl=%b res=%h z=%b tb=%b", alu_ctrl, result, zero, take_branch);
    endtask

    task automatic test_rtype();
        logic [5:0]  functs [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                                    6'b100110, 6'b100111, 6'b101010};
        logic [31:0] wants  [7] = '{32'h16, 32'h02, 32'h08, 32'h0E, 32'h06,
                                    32'hFFFFFFF1, 32'h0};
        for (int i = 0; i < 7; i++) begin
            drive_step(2'b10, functs[i], 1'b0, 32'h0000000C, 32'h0000000A);
            total++;
            if (result !== wants[i]) begin
                bad++;
                $display("FAIL rtype funct=%b got %h want %h", functs[i], result, wants[i]);
            end
            $display("rtype funct=%b ctrl=%b res=%h", functs[i], alu_ctrl, result);
        end
    endtask

    task automatic test_compare();
        drive_step(2'b10, 6'b101010, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        total++;
        if (result !== 32'd1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL slt got res=%h ov=%b want res=1 ov=0", result, overflow);
        end
        $display("slt res=%h", result);
        drive_step(2'b10, 6'b101011, 1'b0, 32'hFFFFFFFF, 32'h00000001);
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || alu_ctrl !== 4'b1000) begin
            bad++;
            $display("FAIL sltu got res=%h z=%b ctrl=%b want res=0 z=1 ctrl=1000", result, zero, alu_ctrl);
        end
        $display("sltu res=%h z=%b", result, zero);
        // Signed compare where the subtraction overflows.
        drive_step(2'b10, 6'b101010, 1'b0, 32'h80000000, 32'h00000001);
        total++;
        if (result !== 32'd1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL slt_ovf got res=%h ov=%b want res=1 ov=0", result, overflow);
        end
        $display("slt_ovf res=%h", result);
    endtask

    task automatic test_overflow();
        drive_step(2'b00, 6'd0, 1'b0, 32'h7FFFFFFF, 32'd1);
        total++;
        if (result !== 32'h80000000 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL add_ovf got res=%h ov=%b want 80000000 1", result, overflow);
        end
        $display("add_ovf res=%h ov=%b", result, overflow);
        drive_step(2'b01, 6'd0, 1'b0, 32'h80000000, 32'd1);
        total++;
        if (result !== 32'h7FFFFFFF || overflow !== 1'b1) begin
            bad++;
            $display("FAIL sub_ovf got res=%h ov=%b want 7fffffff 1", result, overflow);
        end
        $display("sub_ovf res=%h ov=%b", result, overflow);
        drive_step(2'b00, 6'd0, 1'b0, 32'hFFFFFFFF, 32'd1);
        total++;
        if (result !== 32'd0 || zero !== 1'b1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL add_wrap got res=%h z=%b ov=%b want 0 1 0", result, zero, overflow);
        end
        $display("add_wrap res=%h z=%b ov=%b", result, zero, overflow);
    endtask

    task automatic test_branch();
        drive_step(2'b01, 6'd0, 1'b1, 32'h1234, 32'h1234);
        total++;
        if (take_branch !== 1'b1) begin
            bad++;
            $display("FAIL branch_eq got tb=%b want 1", take_branch);
        end
        $display("branch_eq tb=%b", take_branch);
        drive_step(2'b01, 6'd0, 1'b1, 32'h1234, 32'h1235);
        total++;
        if (take_branch !== 1'b0 || zero !== 1'b0) begin
            bad++;
            $display("FAIL branch_ne got tb=%b z=%b want 0 0", take_branch, zero);
        end
        $display("branch_ne tb=%b", take_branch);
        drive_step(2'b01, 6'd0, 1'b0, 32'h1234, 32'h1234);
        total++;
        if (take_branch !== 1'b0 || zero !== 1'b1) begin
            bad++;
            $display("FAIL branch_off got tb=%b z=%b want 0 1", take_branch, zero);
        end
        $display("branch_off tb=%b z=%b", take_branch, zero);
    endtask

    task automatic test_default();
        drive_step(2'b10, 6'b000000, 1'b0, 32'd3, 32'd4);
        total++;
        if (alu_ctrl !== 4'b0010 || result !== 32'd7) begin
            bad++;
            $display("FAIL default_funct got ctrl=%b res=%h want 0010 7", alu_ctrl, result);
        end
        $display("default_funct ctrl=%b res=%h", alu_ctrl, result);
        drive_step(2'b11, 6'b101010, 1'b0, 32'd3, 32'd4);
        total++;
        if (alu_ctrl !== 4'b0010 || result !== 32'd7) begin
            bad++;
            $display("FAIL default_op got ctrl=%b res=%h want 0010 7", alu_ctrl, result);
        end
        $display("default_op ctrl=%b res=%h", alu_ctrl, result);
    endtask

    task automatic test_back_to_back();
        logic [5:0]  fpool [10] = '{6'd32, 6'd33, 6'd34, 6'd35, 6'd36, 6'd37, 6'd38, 6'd39, 6'd42, 6'd43};
        logic [1:0]  op;
        logic [5:0]  f;
        logic        br;
        logic [31:0] x, y;
        logic [3:0]  e_ctrl;
        logic [31:0] e_res;
        logic        e_zero, e_ov, e_tb;
        for (int i = 0; i < 300; i++) begin
            op = 2'($urandom_range(0, 3));
            f  = ($urandom_range(0, 4) == 0) ? 6'($urandom) : fpool[$urandom_range(0, 9)];
            br = 1'($urandom);
            x  = $urandom;
            y  = ($urandom_range(0, 3) == 0) ? x : $urandom;
            if ($urandom_range(0, 7) == 0) y = 32'h80000000 ^ 32'($urandom_range(0, 3));
            model(op, f, br, x, y, e_ctrl, e_res, e_zero, e_ov, e_tb);
            drive_step(op, f, br, x, y);
            total++;
            if (alu_ctrl !== e_ctrl || result !== e_res || zero !== e_zero
                || overflow !== e_ov || take_branch !== e_tb) begin
                bad++;
                $display("FAIL rand%0d op=%b f=%b a=%h b=%h got ctrl=%b res=%h z=%b ov=%b tb=%b want ctrl=%b res=%h z=%b ov=%b tb=%b",
                         i, op, f, x, y, alu_ctrl, result, zero, overflow, take_branch,
                         e_ctrl, e_res, e_zero, e_ov, e_tb);
            end
            $display("rand%0d op=%b f=%b a=%h b=%h res=%h", i, op, f, x, y, result);
            // Inputs changing between edges must not disturb the registered outputs.
            if (i % 25 == 0) begin
                alu_op = ~op; a = ~x; b = x; branch = ~br;
                #2;
                total++;
                if (result !== e_res || alu_ctrl !== e_ctrl) begin
                    bad++;
                    $display("FAIL hold%0d got res=%h ctrl=%b want res=%h ctrl=%b",
                             i, result, alu_ctrl, e_res, e_ctrl);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        drive_step(2'b00, 6'd0, 1'b1, 32'd1, 32'hFFFFFFFF);
        rst = 1'b1;
        drive_step(2'b01, 6'd0, 1'b1, 32'h7, 32'h7);
        total++;
        if ({alu_ctrl, result, zero, overflow, take_branch} !== 39'd0) begin
            bad++;
            $display("FAIL mid_reset got ctrl=%b res=%h z=%b ov=%b tb=%b want all 0",
                     alu_ctrl, result, zero, overflow, take_branch);
        end
        $display("mid_reset ctrl=%b res=%h", alu_ctrl, result);
        @(negedge clk);
        rst = 1'b0;
        alu_op = 2'b10; funct = 6'b100101; a = 32'hF0; b = 32'h0F; branch = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (result !== 32'hFF || alu_ctrl !== 4'b0001) begin
            bad++;
            $display("FAIL post_reset got res=%h ctrl=%b want ff 0001", result, alu_ctrl);
        end
        $display("post_reset res=%h", result);
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        alu_op = 2'b01; funct = 6'd0; branch = 1'b1; a = 32'd5; b = 32'd5;
        test_reset();
        test_rtype();
        test_compare();
        test_overflow();
        test_branch();
        test_default();
        test_back_to_back();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock `clk`, reset `rst`.
REQ-002 The block SHALL provide these ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- alu_op  in  2  main-control ALU operation class
- funct  in  6  instruction bits [5:0]
- branch  in  1  branch flag from main control
- a  in  32  operand A (register read data 1)
- b  in  32  operand B (register data 2 or sign-extended immediate)
- alu_ctrl  out  4  registered decoded ALU control code
- result  out  32  registered ALU result
- zero  out  1  registered, 1 when result == 0
- overflow  out  1  registered signed overflow for ADD/SUB
- take_branch  out  1  registered branch AND zero

Function
REQ-003 The block SHALL decode alu_op/funct combinationally into a 4-bit control code:
- alu_op=00 -> 0010 ADD
- alu_op=01 -> 0110 SUB
- alu_op=11 -> 0010 ADD
- alu_op=10 -> by funct:
  - 100000 or 100001 -> 0010 ADD
  - 100010 or 100011 -> 0110 SUB
  - 100100 -> 0000 AND
  - 100101 -> 0001 OR
  - 100110 -> 0011 XOR
  - 100111 -> 1100 NOR
  - 101010 -> 0111 SLT
  - 101011 -> 1000 SLTU
  - any other funct -> 0010 ADD
REQ-004 The ALU SHALL compute, from the decoded code, combinationally:
- AND: a&b
- OR: a|b
- ADD: a+b mod 2^32
- SUB: a-b mod 2^32
- XOR: a^b
- NOR: ~(a|b)
- SLT: 1 if signed a < signed b, else 0, zero-extended
- SLTU: 1 if unsigned a < unsigned b, else 0, zero-extended
- any undefined code: 0
REQ-005 Overflow SHALL be computed per the ADD/SUB rule below; for all other codes it SHALL be 0.
- ADD: overflow=1 when a and b have the same sign and the sum's sign differs.
- SUB: overflow=1 when a and b have different signs and the difference's sign differs from a.
REQ-006 Zero SHALL be 1 exactly when the 32-bit computed result is all zeros, for every operation.
REQ-007 take_branch SHALL equal branch AND zero, computed from the same cycle's inputs.
REQ-008 On each rising clk with rst=0, the block SHALL register alu_ctrl, result, zero, overflow and take_branch from the current inputs, giving a latency of exactly 1 cycle.
REQ-009 Outputs SHALL be stable between clock edges; input changes between edges SHALL NOT affect outputs until the next edge.
REQ-010 There SHALL be no enable or handshake; a new operation SHALL be accepted every cycle, giving a throughput of 1 per clock.
REQ-011 Wrap-around SHALL be silent: the result keeps the low 32 bits, and only the overflow flag signals signed overflow.
REQ-012 SLT and SLTU SHALL NOT set overflow, and SHALL NOT use the subtract result's overflow to decide the comparison.

Reset
REQ-013 On a rising clk with rst=1, all outputs SHALL be cleared: alu_ctrl=0000, result=0, zero=0, overflow=0, take_branch=0.
REQ-014 rst SHALL have priority over any concurrent input; the first edge with rst=0 SHALL register the inputs present at that edge.
REQ-015 Asserting rst mid-stream SHALL discard the pending operation; no partial state survives reset.

Verification
REQ-016 Reset scenario: hold rst=1 for 2 clocks with a=5, b=5, alu_op=01, branch=1 -> all outputs 0. Then deassert rst -> after 1 edge: alu_ctrl=0110, result=0, zero=1, take_branch=1.
REQ-017 R-type decode scenario: alu_op=10, a=0x0000000C, b=0x0000000A, apply each funct below in turn -> result after 1 edge:
- 100000 -> 0x16
- 100010 -> 0x02
- 100100 -> 0x08
- 100101 -> 0x0E
- 100110 -> 0x06
- 100111 -> 0xFFFFFFF1
- 101010 -> 0x0
REQ-018 Signed/unsigned compare scenario: alu_op=10, a=0xFFFFFFFF, b=0x00000001:
- funct 101010 -> result=1
- funct 101011 -> result=0, zero=1
REQ-019 Overflow scenario:
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1.
- SUB a=0x80000000, b=1 -> result=0x7FFFFFFF, overflow=1.
- ADD a=0xFFFFFFFF, b=1 -> result=0, zero=1, overflow=0.
REQ-020 Branch scenario: alu_op=01, branch=1:
- a=b=0x1234 -> take_branch=1.
- a=0x1234, b=0x1235 -> take_branch=0.
- branch=0 with a=b -> take_branch=0, zero=1.
REQ-021 Default decode scenario:
- alu_op=10, funct=000000, a=3, b=4 -> alu_ctrl=0010, result=7.
- alu_op=11, a=3, b=4 -> result=7.
